// File: rtl/ctrl_unit_fsm_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, ALU codes and
// datapath mux selects, plus the Moore output decode used by the FSM.
package ctrl_unit_fsm_pkg;

  typedef enum logic [3:0] {
    ST_RESET, ST_FETCH, ST_DECODE, ST_R_EXEC, ST_R_WB, ST_I_EXEC, ST_I_WB,
    ST_ADDR, ST_LD_RD, ST_LD_WB, ST_ST_WR, ST_BR, ST_JMP, ST_EXC
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ULA_LOAD = 3'b000;
  localparam logic [2:0] ULA_ADD  = 3'b001;
  localparam logic [2:0] ULA_SUB  = 3'b010;
  localparam logic [2:0] ULA_AND  = 3'b011;
  localparam logic [2:0] ULA_CMP  = 3'b111;

  localparam logic       SEL_A_PC      = 1'b0;
  localparam logic       SEL_A_A       = 1'b1;
  localparam logic [1:0] SEL_B_B       = 2'b00;
  localparam logic [1:0] SEL_B_EXT     = 2'b01;
  localparam logic [1:0] SEL_B_EXT_SH2 = 2'b10;
  localparam logic [1:0] SEL_B_FOUR    = 2'b11;
  localparam logic [1:0] WREG_RT       = 2'b00;
  localparam logic [1:0] WREG_RD       = 2'b01;
  localparam logic [2:0] WDATA_ALUOUT  = 3'b000;
  localparam logic [2:0] WDATA_MEM     = 3'b001;
  localparam logic [2:0] PCSRC_ULA     = 3'b000;
  localparam logic [2:0] PCSRC_ALUOUT  = 3'b001;
  localparam logic [2:0] PCSRC_JUMP    = 3'b010;
  localparam logic [2:0] PCSRC_EXC     = 3'b011;
  localparam logic [2:0] ADDR_PC       = 3'b000;
  localparam logic [2:0] ADDR_ALUOUT   = 3'b001;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_OPCODE = 2'b01;
  localparam logic [1:0] CAUSE_OVF    = 2'b10;

  typedef struct packed {
    logic       pc_w;
    logic       mem_w;
    logic       ir_w;
    logic       rb_w;
    logic       ab_w;
    logic       alu_w;
    logic       epc_w;
    logic [2:0] ula_c;
    logic       sel_a;
    logic [1:0] sel_b;
    logic [1:0] sel_writereg;
    logic [2:0] sel_wdata;
    logic [2:0] sel_aluout;
    logic [2:0] sel_mem;
    logic [1:0] exc_cause;
    logic       rst_out;
  } ctrl_out_t;

  // Branch pc_w depends on the live eq flag and is added outside this decode.
  function automatic ctrl_out_t decode_outputs(input state_t s, input logic fetch_done,
                                               input logic [2:0] r_ula, input logic [1:0] cause);
    ctrl_out_t o;
    o = '0;
    case (s)
      ST_RESET: o.rst_out = 1'b1;
      ST_FETCH: begin
        o.sel_mem = ADDR_PC;
        if (fetch_done) begin
          o.ir_w       = 1'b1;
          o.pc_w       = 1'b1;
          o.sel_a      = SEL_A_PC;
          o.sel_b      = SEL_B_FOUR;
          o.ula_c      = ULA_ADD;
          o.sel_aluout = PCSRC_ULA;
        end
      end
      ST_DECODE: begin
        o.ab_w  = 1'b1;
        o.alu_w = 1'b1;
        o.sel_a = SEL_A_PC;
        o.sel_b = SEL_B_EXT_SH2;
        o.ula_c = ULA_ADD;
      end
      ST_R_EXEC: begin
        o.alu_w = 1'b1;
        o.sel_a = SEL_A_A;
        o.sel_b = SEL_B_B;
        o.ula_c = r_ula;
      end
      ST_R_WB: begin
        o.rb_w         = 1'b1;
        o.sel_writereg = WREG_RD;
        o.sel_wdata    = WDATA_ALUOUT;
      end
      ST_I_EXEC, ST_ADDR: begin
        o.alu_w = 1'b1;
        o.sel_a = SEL_A_A;
        o.sel_b = SEL_B_EXT;
        o.ula_c = ULA_ADD;
      end
      ST_I_WB: begin
        o.rb_w         = 1'b1;
        o.sel_writereg = WREG_RT;
        o.sel_wdata    = WDATA_ALUOUT;
      end
      ST_LD_RD: o.sel_mem = ADDR_ALUOUT;
      ST_LD_WB: begin
        o.rb_w         = 1'b1;
        o.sel_writereg = WREG_RT;
        o.sel_wdata    = WDATA_MEM;
      end
      ST_ST_WR: begin
        o.mem_w   = 1'b1;
        o.sel_mem = ADDR_ALUOUT;
      end
      ST_BR: begin
        o.ula_c      = ULA_CMP;
        o.sel_a      = SEL_A_A;
        o.sel_b      = SEL_B_B;
        o.sel_aluout = PCSRC_ALUOUT;
      end
      ST_JMP: begin
        o.pc_w       = 1'b1;
        o.sel_aluout = PCSRC_JUMP;
      end
      ST_EXC: begin
        o.epc_w      = 1'b1;
        o.sel_a      = SEL_A_PC;
        o.sel_b      = SEL_B_FOUR;
        o.ula_c      = ULA_SUB;
        o.exc_cause  = cause;
        o.pc_w       = 1'b1;
        o.sel_aluout = PCSRC_EXC;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ctrl_unit_fsm_if.sv
// Control bundle between the control unit (master) and the datapath (slave):
// IR fields and ALU flags in, write enables and mux selects out.
interface ctrl_unit_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       of;
  logic       eq;
  logic       pc_w;
  logic       mem_w;
  logic       ir_w;
  logic       rb_w;
  logic       ab_w;
  logic       alu_w;
  logic       epc_w;
  logic [2:0] ula_c;
  logic       sel_a;
  logic [1:0] sel_b;
  logic [1:0] sel_writereg;
  logic [2:0] sel_wdata;
  logic [2:0] sel_aluout;
  logic [2:0] sel_mem;
  logic [1:0] exc_cause;
  logic       rst_out;

  modport master (
    input  opcode, funct, of, eq,
    output pc_w, mem_w, ir_w, rb_w, ab_w, alu_w, epc_w, ula_c, sel_a, sel_b,
           sel_writereg, sel_wdata, sel_aluout, sel_mem, exc_cause, rst_out
  );

  modport slave (
    output opcode, funct, of, eq,
    input  pc_w, mem_w, ir_w, rb_w, ab_w, alu_w, epc_w, ula_c, sel_a, sel_b,
           sel_writereg, sel_wdata, sel_aluout, sel_mem, exc_cause, rst_out
  );
endinterface

// File: rtl/ctrl_unit_fsm_alu_dec.sv
// R-type funct decode: maps funct to an ALU op and flags functs the datapath cannot run.
module ctrl_alu_dec
  import ctrl_unit_fsm_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] ula_c,
  output logic       illegal
);

  always_comb begin
    ula_c   = ULA_LOAD;
    illegal = 1'b0;
    case (funct)
      FN_ADD:  ula_c = ULA_ADD;
      FN_SUB:  ula_c = ULA_SUB;
      FN_AND:  ula_c = ULA_AND;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_unit_fsm.sv
// Multicycle CPU control unit. Define CTRL_EXC_EN to trap bad opcodes/functs and
// arithmetic overflow into an EPC/vector sequence; without it they fall through.
//
// state     | meaning
// ST_RESET  | held in reset, everything idle, rst_out=1
// ST_FETCH  | read instruction at PC, wait MEM_WAIT cycles, load IR and PC+4
// ST_DECODE | load A/B, precompute branch target into ALUOut
// ST_R_EXEC | R-type ALU op from funct
// ST_R_WB   | write ALUOut to rd
// ST_I_EXEC | ADDI: A + sign-ext
// ST_I_WB   | write ALUOut to rt
// ST_ADDR   | LW/SW effective address
// ST_LD_RD  | data read at ALUOut, MEM_WAIT+1 cycles
// ST_LD_WB  | write memory data to rt
// ST_ST_WR  | single-cycle memory write
// ST_BR     | BEQ/BNE compare, conditional PC load from ALUOut
// ST_JMP    | PC <= jump target
// ST_EXC    | EPC <= PC-4, PC <= exception vector
module ctrl_unit_fsm
  import ctrl_unit_fsm_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 3
) (
  input logic             clk,
  input logic             reset,
  ctrl_unit_fsm_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT);

  state_t           st, st_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       cause, cause_nxt;
  ctrl_out_t        out_q;
  logic [2:0]       r_ula;
  logic             r_illegal;
  logic             wait_done;
  logic             br_take;

  ctrl_alu_dec u_alu_dec (
    .funct   (bus.funct),
    .ula_c   (r_ula),
    .illegal (r_illegal)
  );

  assign wait_done = (cnt == CNT_LAST);

  always_comb begin
    st_nxt    = st;
    cause_nxt = cause;
    case (st)
      ST_RESET: st_nxt = ST_FETCH;
      ST_FETCH: if (wait_done) st_nxt = ST_DECODE;
      ST_DECODE: begin
        case (bus.opcode)
          OP_R:         st_nxt = r_illegal ? ST_EXC : ST_R_EXEC;
          OP_ADDI:      st_nxt = ST_I_EXEC;
          OP_LW, OP_SW: st_nxt = ST_ADDR;
          OP_BEQ, OP_BNE: st_nxt = ST_BR;
          OP_J:         st_nxt = ST_JMP;
          default:      st_nxt = ST_EXC;
        endcase
`ifdef CTRL_EXC_EN
        if (st_nxt == ST_EXC) cause_nxt = CAUSE_OPCODE;
`else
        if (st_nxt == ST_EXC) st_nxt = ST_FETCH;
`endif
      end
      ST_R_EXEC: begin
        st_nxt = ST_R_WB;
`ifdef CTRL_EXC_EN
        if (bus.of && (r_ula == ULA_ADD || r_ula == ULA_SUB)) begin
          st_nxt    = ST_EXC;
          cause_nxt = CAUSE_OVF;
        end
`endif
      end
      ST_I_EXEC: begin
        st_nxt = ST_I_WB;
`ifdef CTRL_EXC_EN
        if (bus.of) begin
          st_nxt    = ST_EXC;
          cause_nxt = CAUSE_OVF;
        end
`endif
      end
      ST_ADDR:  st_nxt = (bus.opcode == OP_LW) ? ST_LD_RD : ST_ST_WR;
      ST_LD_RD: if (wait_done) st_nxt = ST_LD_WB;
      default:  st_nxt = ST_FETCH;
    endcase
  end

  // Counter restarts on every state change and saturates at MEM_WAIT.
  always_comb begin
    cnt_nxt = '0;
    if (st_nxt == st) cnt_nxt = wait_done ? cnt : cnt + CNT_W'(1);
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= ST_RESET;
      cnt   <= '0;
      cause <= CAUSE_NONE;
      out_q <= decode_outputs(ST_RESET, 1'b0, ULA_LOAD, CAUSE_NONE);
    end else begin
      st    <= st_nxt;
      cnt   <= cnt_nxt;
      cause <= cause_nxt;
      out_q <= decode_outputs(st_nxt, cnt_nxt == CNT_LAST, r_ula, cause_nxt);
    end
  end

  assign br_take = (st == ST_BR) && ((bus.opcode == OP_BNE) ? !bus.eq : bus.eq);

  assign bus.pc_w         = out_q.pc_w | br_take;
  assign bus.mem_w        = out_q.mem_w;
  assign bus.ir_w         = out_q.ir_w;
  assign bus.rb_w         = out_q.rb_w;
  assign bus.ab_w         = out_q.ab_w;
  assign bus.alu_w        = out_q.alu_w;
  assign bus.epc_w        = out_q.epc_w;
  assign bus.ula_c        = out_q.ula_c;
  assign bus.sel_a        = out_q.sel_a;
  assign bus.sel_b        = out_q.sel_b;
  assign bus.sel_writereg = out_q.sel_writereg;
  assign bus.sel_wdata    = out_q.sel_wdata;
  assign bus.sel_aluout   = out_q.sel_aluout;
  assign bus.sel_mem      = out_q.sel_mem;
  assign bus.exc_cause    = out_q.exc_cause;
  assign bus.rst_out      = out_q.rst_out;

endmodule
